qspi_xfer_fifo: RTL and testbench

Synchronous first-word-fall-through (FWFT) word FIFO that buffers data between the DMA engine and the QSPI shift engine. One instance sits downstream of the DMA engine as the TX FIFO: the DMA writes it, and the shifter drains it. A second instance sits upstream of the DMA engine as the RX FIFO: the shifter writes it, and the DMA drains it. It exports the occupancy level that the DMA engine uses for burst flow control, plus sticky error flags for the CSR block.

---
 rtl/qspi_xfer_fifo_if.sv | 37 +++
 rtl/qspi_xfer_fifo.sv | 90 +++++++++
 tb/tb_qspi_xfer_fifo.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/qspi_xfer_fifo_if.sv
// qspi_xfer_fifo_if
//   Bundles the data, handshake, level and error signals of one QSPI transfer
//   FIFO. Signal names carry the FIFO's own point of view (_i into the FIFO,
//   _o out of it).
//   slave  : the FIFO itself
//   master : the producer/consumer/CSR side driving the FIFO
interface qspi_xfer_fifo_if #(
    parameter int WIDTH        = 32,
    parameter int LEVEL_WIDTH  = 5,
    parameter int THRESH_WIDTH = 5
);
    logic                    flush_i;
    logic                    wr_en_i;
    logic [WIDTH-1:0]        wr_data_i;
    logic                    rd_en_i;
    logic [WIDTH-1:0]        rd_data_o;
    logic [LEVEL_WIDTH-1:0]  level_o;
    logic                    full_o;
    logic                    empty_o;
    logic [THRESH_WIDTH-1:0] thresh_i;
    logic                    thresh_hit_o;
    logic                    overflow_o;
    logic                    underflow_o;
    logic                    err_clr_i;

    modport slave (
        input  flush_i, wr_en_i, wr_data_i, rd_en_i, thresh_i, err_clr_i,
        output rd_data_o, level_o, full_o, empty_o, thresh_hit_o,
               overflow_o, underflow_o
    );

    modport master (
        output flush_i, wr_en_i, wr_data_i, rd_en_i, thresh_i, err_clr_i,
        input  rd_data_o, level_o, full_o, empty_o, thresh_hit_o,
               overflow_o, underflow_o
    );
endinterface

// File: rtl/qspi_xfer_fifo.sv
// qspi_xfer_fifo
//   First-word-fall-through word FIFO between the DMA engine and the QSPI
//   shifter (used as both TX and RX buffer). Exports occupancy, a watermark
//   compare and sticky overflow/underflow flags.
// Ports
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : qspi_xfer_fifo_if.slave (write/read handshake, head data,
//           level/full/empty, threshold compare, sticky error flags, flush)
module qspi_xfer_fifo #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 8,
    parameter int LEVEL_WIDTH  = 5,
    parameter int THRESH_WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    qspi_xfer_fifo_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CMP_W = (LEVEL_WIDTH > THRESH_WIDTH) ? LEVEL_WIDTH : THRESH_WIDTH;
    localparam logic [PTR_W-1:0]       LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [LEVEL_WIDTH-1:0] FULL_LVL = LEVEL_WIDTH'(DEPTH);

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;

    logic full, empty, rd_acc, wr_acc;

    assign full   = (level_q == FULL_LVL);
    assign empty  = (level_q == '0);
    assign rd_acc = bus.rd_en_i && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_acc = bus.wr_en_i && (!full || rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q + LEVEL_WIDTH'(wr_acc) - LEVEL_WIDTH'(rd_acc);
        // Clear first, then a same-cycle error event re-sets the flag.
        overflow_d  = (overflow_q  && !bus.err_clr_i) || (bus.wr_en_i && !wr_acc);
        underflow_d = (underflow_q && !bus.err_clr_i) || (bus.rd_en_i && empty);
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.flush_i) begin
            // Flush drops contents only; sticky flags survive.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!reset && !bus.flush_i && wr_acc) begin
            mem_q[wr_ptr_q] <= bus.wr_data_i;
        end
    end

    assign bus.rd_data_o    = mem_q[rd_ptr_q];
    assign bus.level_o      = level_q;
    assign bus.full_o       = full;
    assign bus.empty_o      = empty;
    assign bus.thresh_hit_o = (CMP_W'(level_q) >= CMP_W'(bus.thresh_i));
    assign bus.overflow_o   = overflow_q;
    assign bus.underflow_o  = underflow_q;
endmodule

// File: tb/tb_qspi_xfer_fifo.sv
module tb_qspi_xfer_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus, driven into a DEPTH=8 and a DEPTH=6 instance.
    logic        rst = 1'b1;
    logic        flush = 1'b0, wr = 1'b0, rd = 1'b0, clr = 1'b0;
    logic [31:0] wd = '0;
    logic [4:0]  th = '0;

    qspi_xfer_fifo_if #(.WIDTH(32), .LEVEL_WIDTH(5), .THRESH_WIDTH(5)) b8 ();
    qspi_xfer_fifo_if #(.WIDTH(32), .LEVEL_WIDTH(5), .THRESH_WIDTH(5)) b6 ();

    assign b8.flush_i = flush;  assign b6.flush_i = flush;
    assign b8.wr_en_i = wr;     assign b6.wr_en_i = wr;
    assign b8.wr_data_i = wd;   assign b6.wr_data_i = wd;
    assign b8.rd_en_i = rd;     assign b6.rd_en_i = rd;
    assign b8.thresh_i = th;    assign b6.thresh_i = th;
    assign b8.err_clr_i = clr;  assign b6.err_clr_i = clr;

    qspi_xfer_fifo #(.WIDTH(32), .DEPTH(8), .LEVEL_WIDTH(5), .THRESH_WIDTH(5)) u_dut8 (
        .clk(clk), .reset(rst), .bus(b8.slave));
    qspi_xfer_fifo #(.WIDTH(32), .DEPTH(6), .LEVEL_WIDTH(5), .THRESH_WIDTH(5)) u_dut6 (
        .clk(clk), .reset(rst), .bus(b6.slave));

    logic [31:0] o_data [2];
    logic [4:0]  o_lvl  [2];
    logic        o_full [2], o_empty [2], o_hit [2], o_ovf [2], o_unf [2];
    assign o_data[0] = b8.rd_data_o;    assign o_data[1] = b6.rd_data_o;
    assign o_lvl[0]  = b8.level_o;      assign o_lvl[1]  = b6.level_o;
    assign o_full[0] = b8.full_o;       assign o_full[1] = b6.full_o;
    assign o_empty[0] = b8.empty_o;     assign o_empty[1] = b6.empty_o;
    assign o_hit[0]  = b8.thresh_hit_o; assign o_hit[1]  = b6.thresh_hit_o;
    assign o_ovf[0]  = b8.overflow_o;   assign o_ovf[1]  = b6.overflow_o;
    assign o_unf[0]  = b8.underflow_o;  assign o_unf[1]  = b6.underflow_o;

    // Reference model: ordered list of expected words per instance, shifted on pop.
    int          dep [2] = '{8, 6};
    logic [31:0] exq [2][16];
    int          cnt [2];
    logic        m_ovf [2], m_unf [2];
    bit          armed = 1'b0;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut_depth%0d t=%0t got %h expected %h", name, dep[k], $time, act, exp);
        end
    endtask

    // Monitor: compare DUT against model at negedge, then advance the model
    // with the inputs that the next rising edge will sample.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (armed) begin
                chk("level", k, 32'(o_lvl[k]), 32'(cnt[k]));
                chk("full",  k, 32'(o_full[k]),  32'(cnt[k] == dep[k]));
                chk("empty", k, 32'(o_empty[k]), 32'(cnt[k] == 0));
                chk("thresh_hit", k, 32'(o_hit[k]), 32'(cnt[k] >= int'(th)));
                chk("overflow",  k, 32'(o_ovf[k]), 32'(m_ovf[k]));
                chk("underflow", k, 32'(o_unf[k]), 32'(m_unf[k]));
                if (cnt[k] > 0) chk("head_data", k, o_data[k], exq[k][0]);
            end
            if (rst) begin
                cnt[k] = 0; m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
            end else if (flush) begin
                cnt[k] = 0;
            end else begin
                bit ra, wa;
                ra = rd && cnt[k] > 0;
                wa = wr && (cnt[k] < dep[k] || ra);
                if (clr) begin m_ovf[k] = 1'b0; m_unf[k] = 1'b0; end
                if (wr && !wa) m_ovf[k] = 1'b1;
                if (rd && cnt[k] == 0) m_unf[k] = 1'b1;
                if (ra) begin
                    for (int j = 0; j < 15; j++) exq[k][j] = exq[k][j+1];
                    cnt[k]--;
                end
                if (wa) begin
                    exq[k][cnt[k]] = wd;
                    cnt[k]++;
                end
            end
        end
        if (rst) armed = 1'b1;
    end

    task automatic step(input logic r, input logic f, input logic w, input logic [31:0] d,
                        input logic rr, input logic c);
        @(posedge clk); #1;
        rst = r; flush = f; wr = w; wd = d; rd = rr; clr = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0);
    endtask

    logic [31:0] words [4];
    int lv, nw;

    initial begin
        words[0] = 32'h0102_0304; words[1] = 32'h1112_1314;
        words[2] = 32'h2122_2324; words[3] = 32'h3132_3334;

        // Reset then idle with thresh 0.
        step(1, 0, 0, '0, 0, 0);
        idle(2);

        // Four writes, then four zero-latency reads.
        for (int i = 0; i < 4; i++) step(0, 0, 1, words[i], 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1, 0);
        idle(1);

        // Fill, overflow with a lone write, then simultaneous write+read at full.
        th = 5'd4;
        for (int i = 0; i < 8; i++) step(0, 0, 1, 32'hA000_0000 + 32'(i), 0, 0);
        idle(1);
        step(0, 0, 1, 32'hDEAD_BEEF, 0, 0);
        idle(1);
        step(0, 0, 1, 32'hC0DE_0001, 1, 0);
        idle(1);
        step(0, 0, 0, '0, 0, 1);
        idle(1);

        // Wrap-around with level held in 1..3.
        step(0, 1, 0, '0, 0, 0);
        lv = 0; nw = 0;
        while (nw < 20) begin
            int pick;
            logic w, r;
            pick = $urandom_range(0, 2);
            w = (lv < 2) || (lv == 2 && pick != 1);
            r = (lv > 2) || (lv == 2 && pick != 0) || (lv == 1 && pick == 2);
            if (lv == 0) r = 0;
            step(0, 0, w, $urandom, r, 0);
            if (w) nw++;
            lv = lv + int'(w) - int'(r);
        end
        while (lv > 0) begin step(0, 0, 0, '0, 1, 0); lv--; end
        idle(1);

        // Underflow, clear, clear together with a new empty read.
        step(0, 0, 0, '0, 0, 1);
        step(0, 0, 0, '0, 1, 0);
        idle(1);
        step(0, 0, 0, '0, 0, 1);
        idle(1);
        step(0, 0, 0, '0, 1, 1);
        idle(1);

        // Flush with write; fill then reset.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 32'hB000_0000 + 32'(i), 0, 0);
        step(0, 1, 1, 32'h5555_AAAA, 0, 0);
        idle(1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'hB100_0000 + 32'(i), 0, 0);
        step(1, 0, 1, 32'h7777_7777, 0, 0);
        idle(1);

        // Watermark at 4 while filling to 8.
        th = 5'd4;
        for (int i = 0; i < 9; i++) step(0, 0, 1, $urandom, 0, 0);
        idle(1);
        step(0, 1, 0, '0, 0, 1);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) th = 5'($urandom_range(0, 9));
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 9) < 6), $urandom,
                 ($urandom_range(0, 9) < 5), ($urandom_range(0, 7) == 0));
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
